// File: rtl/main_memory_burst_if.sv
// Request/response bundle between the cache controller (master) and main_memory_burst (slave).
// resp_err exists only when MEM_RANGE_CHECK_EN is defined.
interface main_memory_burst_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 16
);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic [DATA_W-1:0] rdata;
  logic              rdata_valid;
  logic              rdata_last;
  logic              wr_done;
`ifdef MEM_RANGE_CHECK_EN
  logic              resp_err;
`endif

  modport master (
    output req_valid, req_we, req_addr, req_wdata,
    input  req_ready, rdata, rdata_valid, rdata_last, wr_done
`ifdef MEM_RANGE_CHECK_EN
    , input resp_err
`endif
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata,
    output req_ready, rdata, rdata_valid, rdata_last, wr_done
`ifdef MEM_RANGE_CHECK_EN
    , output resp_err
`endif
  );
endinterface

// File: rtl/main_memory_burst.sv
// Single-port word memory with valid/ready requests, fixed-latency writes and wrapping burst reads.
// Define MEM_RANGE_CHECK_EN to flag and suppress accesses at or above DEPTH via resp_err.
module main_memory_burst #(
  parameter int DATA_W    = 8,
  parameter int ADDR_W    = 16,
  parameter int DEPTH     = 65536,
  parameter int READ_LAT  = 2,
  parameter int WRITE_LAT = 2,
  parameter int BURST_LEN = 4
) (
  input logic                clk,
  input logic                rst_n,
  main_memory_burst_if.slave bus
);
  localparam int B       = $clog2(BURST_LEN);
  localparam int BEAT_W  = B + 1;
  localparam int LAT_MAX = (READ_LAT > WRITE_LAT) ? READ_LAT : WRITE_LAT;
  localparam int LAT_W   = $clog2(LAT_MAX + 1);
  localparam int IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [ADDR_W-1:0] LOW_MASK    = ADDR_W'(BURST_LEN - 1);
  localparam logic [LAT_W-1:0]  RD_WAIT_END = LAT_W'((READ_LAT > 1) ? READ_LAT - 2 : 0);
  localparam logic [LAT_W-1:0]  WR_WAIT_END = LAT_W'(WRITE_LAT - 1);
  localparam logic [BEAT_W-1:0] BEAT_END    = BEAT_W'(BURST_LEN);
  localparam logic [BEAT_W-1:0] BEAT_LAST   = BEAT_W'(BURST_LEN - 1);

  typedef enum logic [1:0] {IDLE, RD_WAIT, RD_BURST, WR_WAIT} state_t;

  state_t            state_reg, state_next;
  logic [LAT_W-1:0]  lat_cnt_reg;
  logic [BEAT_W-1:0] beat_cnt_reg;
  logic [ADDR_W-1:0] addr_reg;
  logic [DATA_W-1:0] wdata_reg;
  logic [DATA_W-1:0] mem_q_reg;
  logic              rdata_valid_reg, rdata_last_reg, wr_done_reg;

  logic              accept, beat_fire, beat_last, wr_fire, mem_we, in_range;
  logic [ADDR_W-1:0] beat_addr;
  logic [IDX_W-1:0]  mem_idx;

  logic [DATA_W-1:0] mem [DEPTH];

  assign accept = bus.req_valid && (state_reg == IDLE);

  // Low B bits advance modulo BURST_LEN; upper bits stay on the aligned block.
  assign beat_addr = (addr_reg & ~LOW_MASK) | ((addr_reg + ADDR_W'(beat_cnt_reg)) & LOW_MASK);
  assign mem_idx   = beat_addr[IDX_W-1:0];

`ifdef MEM_RANGE_CHECK_EN
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);
  logic err_reg;
  assign in_range = ({1'b0, beat_addr} < DEPTH_L);
`else
  assign in_range = 1'b1;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (accept) begin
          if (bus.req_we) state_next = WR_WAIT;
          else            state_next = (READ_LAT > 1) ? RD_WAIT : RD_BURST;
        end
      end
      RD_WAIT:  if (lat_cnt_reg == RD_WAIT_END) state_next = RD_BURST;
      // One extra cycle after the last beat keeps req_ready low while it is on the bus.
      RD_BURST: if (beat_cnt_reg == BEAT_END)   state_next = IDLE;
      WR_WAIT:  if (lat_cnt_reg == WR_WAIT_END) state_next = IDLE;
      default:  state_next = IDLE;
    endcase
  end

  always_comb begin
    bus.req_ready = (state_reg == IDLE);
    beat_fire     = (state_reg == RD_BURST) && (beat_cnt_reg != BEAT_END);
    beat_last     = beat_fire && (beat_cnt_reg == BEAT_LAST);
    wr_fire       = (state_reg == WR_WAIT) && (lat_cnt_reg == WR_WAIT_END);
    mem_we        = wr_fire && in_range;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lat_cnt_reg  <= '0;
      beat_cnt_reg <= '0;
      addr_reg     <= '0;
      wdata_reg    <= '0;
    end else if (accept) begin
      lat_cnt_reg  <= '0;
      beat_cnt_reg <= '0;
      addr_reg     <= bus.req_addr;
      wdata_reg    <= bus.req_wdata;
    end else begin
      if (state_reg == RD_WAIT || state_reg == WR_WAIT) lat_cnt_reg <= lat_cnt_reg + 1'b1;
      if (beat_fire) beat_cnt_reg <= beat_cnt_reg + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_valid_reg <= 1'b0;
      rdata_last_reg  <= 1'b0;
      wr_done_reg     <= 1'b0;
`ifdef MEM_RANGE_CHECK_EN
      err_reg         <= 1'b0;
`endif
    end else begin
      rdata_valid_reg <= beat_fire;
      rdata_last_reg  <= beat_last;
      wr_done_reg     <= wr_fire;
`ifdef MEM_RANGE_CHECK_EN
      err_reg         <= (beat_fire || wr_fire) && !in_range;
`endif
    end
  end

  // Array contents deliberately survive reset; only the registered read port feeds rdata.
  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_idx] <= wdata_reg;
    mem_q_reg <= mem[mem_idx];
  end

  assign bus.rdata_valid = rdata_valid_reg;
  assign bus.rdata_last  = rdata_last_reg;
  assign bus.wr_done     = wr_done_reg;
`ifdef MEM_RANGE_CHECK_EN
  assign bus.resp_err    = err_reg;
  assign bus.rdata       = (rdata_valid_reg && !err_reg) ? mem_q_reg : '0;
`else
  assign bus.rdata       = rdata_valid_reg ? mem_q_reg : '0;
`endif
endmodule

// File: tb/tb_main_memory_burst.sv
// Directed bench for main_memory_burst: writes, wrapping bursts, busy-time input hold, resets mid-operation.
// A BURST_LEN=1 instance covers single-beat reads; range cases run when MEM_RANGE_CHECK_EN is defined.
`timescale 1ns/1ps
module tb_main_memory_burst;
`ifdef MEM_RANGE_CHECK_EN
  localparam int DEPTH = 16;
`else
  localparam int DEPTH = 65536;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  main_memory_burst_if #(.DATA_W(8), .ADDR_W(16)) bus ();
  main_memory_burst_if #(.DATA_W(8), .ADDR_W(16)) bus1 ();

  main_memory_burst #(
    .DATA_W(8), .ADDR_W(16), .DEPTH(DEPTH),
    .READ_LAT(2), .WRITE_LAT(2), .BURST_LEN(4)
  ) u_dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  main_memory_burst #(
    .DATA_W(8), .ADDR_W(16), .DEPTH(65536),
    .READ_LAT(2), .WRITE_LAT(2), .BURST_LEN(1)
  ) u_dut1 (
    .clk(clk), .rst_n(rst_n), .bus(bus1)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_check(input string tag);
    check({tag, "_ready"}, bus.req_ready, 1);
    check({tag, "_valid"}, bus.rdata_valid, 0);
    check({tag, "_last"}, bus.rdata_last, 0);
    check({tag, "_wr_done"}, bus.wr_done, 0);
    check({tag, "_rdata"}, bus.rdata, 0);
  endtask

  task automatic do_write(input logic [15:0] addr, input logic [7:0] data, input logic exp_err);
    check("wr_start_ready", bus.req_ready, 1);
    bus.req_valid = 1'b1;
    bus.req_we    = 1'b1;
    bus.req_addr  = addr;
    bus.req_wdata = data;
    step();
    bus.req_valid = 1'b0;
    check("wr_busy_ready", bus.req_ready, 0);
    check("wr_early_done", bus.wr_done, 0);
    step();
    check("wr_early_done", bus.wr_done, 0);
    step();
    check("wr_done", bus.wr_done, 1);
    check("wr_ready_back", bus.req_ready, 1);
`ifdef MEM_RANGE_CHECK_EN
    check("wr_resp_err", bus.resp_err, exp_err);
`endif
    $display("write addr=0x%04h data=0x%02h exp_err=%0d", addr, data, exp_err);
  endtask

  task automatic read_burst(input logic [15:0] addr, input logic [7:0] e0, input logic [7:0] e1,
                            input logic [7:0] e2, input logic [7:0] e3,
                            input logic [3:0] err_mask, input logic hold);
    logic [7:0] exp [4];
    exp = '{e0, e1, e2, e3};
    check("rd_start_ready", bus.req_ready, 1);
    bus.req_valid = 1'b1;
    bus.req_we    = 1'b0;
    bus.req_addr  = addr;
    step();
    if (hold) begin
      bus.req_we    = 1'b1;
      bus.req_addr  = 16'h0100;
      bus.req_wdata = 8'hEE;
    end else begin
      bus.req_valid = 1'b0;
    end
    check("rd_busy_ready", bus.req_ready, 0);
    check("rd_early_valid", bus.rdata_valid, 0);
    step();
    check("rd_early_valid", bus.rdata_valid, 0);
    for (int i = 0; i < 4; i++) begin
      if (hold) begin
        bus.req_addr = bus.req_addr + 16'd1;
        bus.req_we   = ~bus.req_we;
      end
      step();
      check("rd_valid", bus.rdata_valid, 1);
      check("rd_data", bus.rdata, exp[i]);
      check("rd_last", bus.rdata_last, (i == 3) ? 1 : 0);
      check("rd_busy", bus.req_ready, 0);
`ifdef MEM_RANGE_CHECK_EN
      check("rd_resp_err", bus.resp_err, err_mask[i]);
`endif
    end
    step();
    bus.req_valid = 1'b0;
    check("rd_end_valid", bus.rdata_valid, 0);
    check("rd_end_rdata", bus.rdata, 0);
    check("rd_end_last", bus.rdata_last, 0);
    check("rd_end_ready", bus.req_ready, 1);
    $display("read addr=0x%04h exp=%02h %02h %02h %02h err_mask=%b hold=%0d",
             addr, e0, e1, e2, e3, err_mask, hold);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.req_valid = 1'b0;  bus.req_we = 1'b0;  bus.req_addr = '0;  bus.req_wdata = '0;
    bus1.req_valid = 1'b0; bus1.req_we = 1'b0; bus1.req_addr = '0; bus1.req_wdata = '0;
    repeat (3) @(posedge clk);
    #1;
    idle_check("in_reset");
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      idle_check("post_reset");
    end

    do_write(16'h0004, 8'h40, 1'b0);
    do_write(16'h0005, 8'h41, 1'b0);
    do_write(16'h0006, 8'h42, 1'b0);
    do_write(16'h0007, 8'h43, 1'b0);
    read_burst(16'h0006, 8'h42, 8'h43, 8'h40, 8'h41, 4'b0000, 1'b0);
    read_burst(16'h0004, 8'h40, 8'h41, 8'h42, 8'h43, 4'b0000, 1'b1);
    read_burst(16'h0005, 8'h41, 8'h42, 8'h43, 8'h40, 4'b0000, 1'b0);

    // Single-beat instance: write 0xA5 then read it back.
    check("bl1_ready", bus1.req_ready, 1);
    bus1.req_valid = 1'b1; bus1.req_we = 1'b1; bus1.req_addr = 16'h0010; bus1.req_wdata = 8'hA5;
    step();
    bus1.req_valid = 1'b0;
    check("bl1_wr_early", bus1.wr_done, 0);
    step();
    check("bl1_wr_early", bus1.wr_done, 0);
    step();
    check("bl1_wr_done", bus1.wr_done, 1);
    check("bl1_wr_ready", bus1.req_ready, 1);
    bus1.req_valid = 1'b1; bus1.req_we = 1'b0; bus1.req_addr = 16'h0010;
    step();
    bus1.req_valid = 1'b0;
    check("bl1_wr_done_clear", bus1.wr_done, 0);
    check("bl1_rd_early", bus1.rdata_valid, 0);
    step();
    check("bl1_rd_early", bus1.rdata_valid, 0);
    step();
    check("bl1_rd_valid", bus1.rdata_valid, 1);
    check("bl1_rd_data", bus1.rdata, 8'hA5);
    check("bl1_rd_last", bus1.rdata_last, 1);
    check("bl1_rd_busy", bus1.req_ready, 0);
    step();
    check("bl1_rd_end_valid", bus1.rdata_valid, 0);
    check("bl1_rd_end_rdata", bus1.rdata, 0);
    check("bl1_rd_end_ready", bus1.req_ready, 1);
    $display("bl1 write/read addr=0x0010 data=0xa5");

    // Reset asserted after beat 1 of a 4-beat burst.
    bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.req_addr = 16'h0004;
    step();
    bus.req_valid = 1'b0;
    step();
    step();
    check("rst_rd_beat0", bus.rdata, 8'h40);
    step();
    check("rst_rd_beat1", bus.rdata, 8'h41);
    rst_n = 1'b0;
    #1;
    idle_check("rst_rd_abort");
    step();
    idle_check("rst_rd_held");
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      idle_check("rst_rd_after");
    end
    $display("reset during read burst");

    // Reset asserted in WR_WAIT before the update edge: write of 0x77 must be dropped.
    bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_addr = 16'h0005; bus.req_wdata = 8'h77;
    step();
    bus.req_valid = 1'b0;
    step();
    check("rst_wr_early", bus.wr_done, 0);
    rst_n = 1'b0;
    #1;
    idle_check("rst_wr_abort");
    step();
    idle_check("rst_wr_held");
    rst_n = 1'b1;
    step();
    idle_check("rst_wr_after");
    $display("reset during write wait");
    read_burst(16'h0004, 8'h40, 8'h41, 8'h42, 8'h43, 4'b0000, 1'b0);

`ifdef MEM_RANGE_CHECK_EN
    do_write(16'h000C, 8'hC0, 1'b0);
    do_write(16'h000D, 8'hD0, 1'b0);
    do_write(16'h000E, 8'hE0, 1'b0);
    do_write(16'h000F, 8'hF0, 1'b0);
    do_write(16'h0012, 8'h99, 1'b1);
    step();
    check("range_err_clear", bus.resp_err, 0);
    read_burst(16'h000E, 8'hE0, 8'hF0, 8'hC0, 8'hD0, 4'b0000, 1'b0);
    read_burst(16'h0012, 8'h00, 8'h00, 8'h00, 8'h00, 4'b1111, 1'b0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
